// File: rtl/fsub_pipe_if.sv
// Handshake bundle for fsub_pipe: operand pair in, difference out, valid/ready on each side.
interface fsub_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/fsub_pipe.sv
// Three-stage pipelined IEEE-754 single subtractor y = x1 - x2, RNE, specials resolved in-block.
// Define FSUB_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module fsub_pipe (
  input  logic       clk,
  input  logic       rst,
  fsub_pipe_if.slave bus
);

  logic adv;
  assign adv          = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- stage 1: unpack, specials, align ----------------
  logic [7:0]  ea, eb, el, es, ediff;
  logic [23:0] ga, gb, gl, gs;
  logic        sa, sb, sl, ss, a_big;
  logic [4:0]  dsh;
  logic [54:0] sh55;
  logic [26:0] al, as;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic        spec_d;
  logic [31:0] spec_y_d;

  always_comb begin
    sa = bus.x1[31];
    sb = ~bus.x2[31];
`ifdef FSUB_SUBNORMAL_EN
    ea = (bus.x1[30:23] == 8'd0) ? 8'd1 : bus.x1[30:23];
    eb = (bus.x2[30:23] == 8'd0) ? 8'd1 : bus.x2[30:23];
    ga = {|bus.x1[30:23], bus.x1[22:0]};
    gb = {|bus.x2[30:23], bus.x2[22:0]};
`else
    ea = bus.x1[30:23];
    eb = bus.x2[30:23];
    ga = (bus.x1[30:23] == 8'd0) ? 24'd0 : {1'b1, bus.x1[22:0]};
    gb = (bus.x2[30:23] == 8'd0) ? 24'd0 : {1'b1, bus.x2[22:0]};
`endif
    // Ties pick x1 so that (-0) - (+0) keeps the minus sign.
    a_big = {ea, ga} >= {eb, gb};
    el    = a_big ? ea : eb;
    es    = a_big ? eb : ea;
    gl    = a_big ? ga : gb;
    gs    = a_big ? gb : ga;
    sl    = a_big ? sa : sb;
    ss    = a_big ? sb : sa;
    ediff = el - es;
    dsh   = (ediff > 8'd31) ? 5'd31 : ediff[4:0];
    sh55  = {gs, 31'd0} >> dsh;
    al    = {gl, 3'b000};
    as    = {sh55[54:29], |sh55[28:0]};

    nan_a = (&bus.x1[30:23]) & (|bus.x1[22:0]);
    nan_b = (&bus.x2[30:23]) & (|bus.x2[22:0]);
    inf_a = (&bus.x1[30:23]) & ~(|bus.x1[22:0]);
    inf_b = (&bus.x2[30:23]) & ~(|bus.x2[22:0]);
    spec_d   = 1'b1;
    spec_y_d = 32'h7FC0_0000;
    if (nan_a | nan_b | (inf_a & inf_b & (bus.x1[31] == bus.x2[31]))) begin
      spec_y_d = 32'h7FC0_0000;
    end else if (inf_a) begin
      spec_y_d = bus.x1;
    end else if (inf_b) begin
      spec_y_d = {~bus.x2[31], bus.x2[30:0]};
    end else begin
      spec_d = 1'b0;
    end
  end

  logic        s1_valid_q, s1_sign_l_q, s1_sign_s_q, s1_spec_q;
  logic [7:0]  s1_exp_q;
  logic [26:0] s1_sig_l_q, s1_sig_s_q;
  logic [31:0] s1_spec_y_q;

  // ---------------- stage 2: add / subtract ----------------
  logic        eff_sub, s2_sign_d;
  logic [27:0] sum_d;

  always_comb begin
    eff_sub = s1_sign_l_q ^ s1_sign_s_q;
    sum_d   = eff_sub ? ({1'b0, s1_sig_l_q} - {1'b0, s1_sig_s_q})
                      : ({1'b0, s1_sig_l_q} + {1'b0, s1_sig_s_q});
    // Exact cancellation yields +0; like-signed zeros keep their sign.
    s2_sign_d = (eff_sub && sum_d == 28'd0) ? 1'b0 : s1_sign_l_q;
  end

  logic        s2_valid_q, s2_sign_q, s2_spec_q;
  logic [7:0]  s2_exp_q;
  logic [27:0] s2_sum_q;
  logic [31:0] s2_spec_y_q;

  // ---------------- stage 3: normalize, round, pack ----------------
  logic [4:0]  lz;
  logic [7:0]  lim, sh;
  logic [26:0] norm_m;
  logic [9:0]  exp_n, exp_r;
  logic        inc, is_normal;
  logic [24:0] rnd;
  logic [22:0] frac;
  logic [31:0] y_d;
  logic        ovf_d;

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (s2_sum_q[i]) lz = 5'(26 - i);
    end
    lim = (s2_exp_q == 8'd0) ? 8'd0 : s2_exp_q - 8'd1;
    sh  = ({3'b000, lz} < lim) ? {3'b000, lz} : lim;
    if (s2_sum_q[27]) begin
      norm_m = {s2_sum_q[27:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n  = {2'b00, s2_exp_q} + 10'd1;
    end else begin
      norm_m = s2_sum_q[26:0] << sh;
      exp_n  = {2'b00, s2_exp_q} - {2'b00, sh};
    end
    inc = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
    rnd = {1'b0, norm_m[26:3]} + {24'd0, inc};
    if (rnd[24]) begin
      frac  = rnd[23:1];
      exp_r = exp_n + 10'd1;
    end else begin
      frac  = rnd[22:0];
      exp_r = exp_n;
    end
    is_normal = rnd[24] | rnd[23];

    ovf_d = 1'b0;
    if (s2_spec_q) begin
      y_d = s2_spec_y_q;
    end else if (s2_sum_q == 28'd0) begin
      y_d = {s2_sign_q, 31'd0};
    end else if (exp_r >= 10'd255) begin
      y_d   = {s2_sign_q, 8'hFF, 23'd0};
      ovf_d = 1'b1;
`ifdef FSUB_SUBNORMAL_EN
    end else begin
      y_d = {s2_sign_q, is_normal ? exp_r[7:0] : 8'd0, frac};
    end
`else
    end else if (!norm_m[26] || !is_normal) begin
      y_d = {s2_sign_q, 31'd0};
    end else begin
      y_d = {s2_sign_q, exp_r[7:0], frac};
    end
`endif
  end

  logic        s3_valid_q, ovf_q;
  logic [31:0] y_q;

  assign bus.out_valid = s3_valid_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      y_q        <= 32'd0;
      ovf_q      <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= bus.in_valid;
      s1_sign_l_q <= sl;
      s1_sign_s_q <= ss;
      s1_exp_q    <= el;
      s1_sig_l_q  <= al;
      s1_sig_s_q  <= as;
      s1_spec_q   <= spec_d;
      s1_spec_y_q <= spec_y_d;

      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s2_sign_d;
      s2_exp_q    <= s1_exp_q;
      s2_sum_q    <= sum_d;
      s2_spec_q   <= s1_spec_q;
      s2_spec_y_q <= s1_spec_y_q;

      s3_valid_q  <= s2_valid_q;
      // Output holds its last value across bubbles.
      if (s2_valid_q) begin
        y_q   <= y_d;
        ovf_q <= ovf_d;
      end
    end
  end

endmodule
